// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate/commit, CDB writeback with decode bypass,
// branch-mispredict flush and store/load ordering checks across pointer wrap-around.
module rob_param #(
    parameter int SIZE   = 8,
    parameter int XLEN   = 32,
    parameter int NUM_LD = 3,
    localparam int PTR_W = $clog2(SIZE)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     alloc_valid_in,
    input  logic [3:0]               alloc_itype_in,
    input  logic [XLEN-1:0]          alloc_value_in,
    input  logic [XLEN-1:0]          alloc_dest_in,
    output logic                     alloc_ready_out,
    output logic [PTR_W-1:0]         alloc_ix_out,
    input  logic                     cdb_valid_in,
    input  logic [PTR_W-1:0]         cdb_ix_in,
    input  logic [XLEN-1:0]          cdb_value_in,
    input  logic [XLEN-1:0]          cdb_addr_in,
    input  logic [PTR_W-1:0]         src1_ix_in,
    input  logic [PTR_W-1:0]         src2_ix_in,
    output logic [XLEN-1:0]          src1_value_out,
    output logic [XLEN-1:0]          src2_value_out,
    output logic                     src1_ready_out,
    output logic                     src2_ready_out,
    output logic                     commit_valid_out,
    output logic                     store_valid_out,
    input  logic                     store_ack_in,
    output logic [PTR_W-1:0]         commit_ix_out,
    output logic [3:0]               commit_itype_out,
    output logic [XLEN-1:0]          commit_value_out,
    output logic [XLEN-1:0]          commit_dest_out,
    input  logic                     flush_valid_in,
    input  logic [PTR_W-1:0]         flush_ix_in,
    input  logic [NUM_LD*PTR_W-1:0]  ld_ix_in,
    input  logic [NUM_LD*XLEN-1:0]   ld_addr_in,
    output logic [NUM_LD-1:0]        can_load_out,
    output logic [PTR_W:0]           count_out
);

    localparam logic [3:0] ITYPE_STORE = 4'h2;

    logic [PTR_W:0]     head_q, head_d, tail_q, tail_d;
    logic [SIZE-1:0]    valid_q, valid_d, ready_q, ready_d;
    logic [3:0]         itype_q [SIZE];
    logic [3:0]         itype_d [SIZE];
    logic [XLEN-1:0]    value_q [SIZE];
    logic [XLEN-1:0]    value_d [SIZE];
    logic [XLEN-1:0]    dest_q  [SIZE];
    logic [XLEN-1:0]    dest_d  [SIZE];

    logic [PTR_W:0]     count;
    logic               full, empty, head_ready, head_store, retire, do_alloc;
    logic [PTR_W-1:0]   head_slot, tail_slot, flush_dist;
    logic [SIZE-1:0]    squash;

    // Age of a slot relative to the head; oldest entry has age 0.
    function automatic logic [PTR_W-1:0] age_of(input logic [PTR_W-1:0] slot,
                                                 input logic [PTR_W-1:0] head);
        return slot - head;
    endfunction

    assign count      = tail_q - head_q;
    assign full       = (count == (PTR_W+1)'(SIZE));
    assign empty      = (count == '0);
    assign head_slot  = head_q[PTR_W-1:0];
    assign tail_slot  = tail_q[PTR_W-1:0];
    assign flush_dist = age_of(flush_ix_in, head_slot);

    assign head_ready = !empty && ready_q[head_slot];
    assign head_store = (itype_q[head_slot] == ITYPE_STORE);
    assign retire     = (head_ready && !head_store) || (head_ready && head_store && store_ack_in);

    assign alloc_ready_out = !full && !flush_valid_in;
    assign alloc_ix_out    = tail_slot;
    assign do_alloc        = alloc_valid_in && alloc_ready_out;

    assign commit_valid_out = head_ready && !head_store;
    assign store_valid_out  = head_ready && head_store;
    assign commit_ix_out    = head_slot;
    assign commit_itype_out = itype_q[head_slot];
    assign commit_value_out = value_q[head_slot];
    assign commit_dest_out  = dest_q[head_slot];
    assign count_out        = count;

    always_comb begin
        squash = '0;
        for (int j = 0; j < SIZE; j++) begin
            if (flush_valid_in && (age_of(PTR_W'(j), head_slot) > flush_dist))
                squash[j] = 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        ready_d = ready_q;
        itype_d = itype_q;
        value_d = value_q;
        dest_d  = dest_q;

        if (cdb_valid_in && valid_q[cdb_ix_in] && !squash[cdb_ix_in]) begin
            ready_d[cdb_ix_in] = 1'b1;
            value_d[cdb_ix_in] = cdb_value_in;
            if (itype_q[cdb_ix_in] == ITYPE_STORE)
                dest_d[cdb_ix_in] = dest_q[cdb_ix_in] + cdb_addr_in;
        end

        if (flush_valid_in) begin
            tail_d  = head_q + {1'b0, flush_dist} + (PTR_W+1)'(1);
            valid_d = valid_d & ~squash;
            ready_d = ready_d & ~squash;
        end

        if (do_alloc) begin
            valid_d[tail_slot] = 1'b1;
            ready_d[tail_slot] = 1'b0;
            itype_d[tail_slot] = alloc_itype_in;
            value_d[tail_slot] = alloc_value_in;
            dest_d[tail_slot]  = alloc_dest_in;
            tail_d             = tail_q + (PTR_W+1)'(1);
        end

        // The head is never younger than a flushed branch, so retire composes with flush.
        if (retire) begin
            valid_d[head_slot] = 1'b0;
            ready_d[head_slot] = 1'b0;
            head_d             = head_q + (PTR_W+1)'(1);
        end
    end

    always_comb begin
        src1_value_out = value_q[src1_ix_in];
        src1_ready_out = ready_q[src1_ix_in];
        src2_value_out = value_q[src2_ix_in];
        src2_ready_out = ready_q[src2_ix_in];
        if (cdb_valid_in && cdb_ix_in == src1_ix_in) begin
            src1_value_out = cdb_value_in;
            src1_ready_out = 1'b1;
        end
        if (cdb_valid_in && cdb_ix_in == src2_ix_in) begin
            src2_value_out = cdb_value_in;
            src2_ready_out = 1'b1;
        end
    end

    // A load waits on any older store that is unresolved or resolved to the same address.
    always_comb begin
        can_load_out = '1;
        for (int i = 0; i < NUM_LD; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                if (valid_q[j] && (itype_q[j] == ITYPE_STORE)
                    && (age_of(PTR_W'(j), head_slot) < age_of(ld_ix_in[i*PTR_W +: PTR_W], head_slot))
                    && (!ready_q[j] || (dest_q[j] == ld_addr_in[i*XLEN +: XLEN])))
                    can_load_out[i] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: payload arrays are not reset; valid_q/ready_q gate every use of their contents.
    always_ff @(posedge clk_in) begin
        itype_q <= itype_d;
        value_q <= value_d;
        dest_q  <= dest_d;
    end

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: directed scenarios plus randomized traffic,
// compared every cycle against an age-ordered queue model of the buffer.
module tb_rob_param;

    localparam int SIZE   = 8;
    localparam int XLEN   = 32;
    localparam int NUM_LD = 3;
    localparam int PTR_W  = 3;
    localparam logic [3:0] ST  = 4'h2;
    localparam logic [3:0] ALU = 4'h0;
    localparam logic [3:0] LD  = 4'h1;

    logic                    clk_in = 1'b0;
    logic                    rst_in;
    logic                    alloc_valid_in;
    logic [3:0]              alloc_itype_in;
    logic [XLEN-1:0]         alloc_value_in, alloc_dest_in;
    logic                    alloc_ready_out;
    logic [PTR_W-1:0]        alloc_ix_out;
    logic                    cdb_valid_in;
    logic [PTR_W-1:0]        cdb_ix_in;
    logic [XLEN-1:0]         cdb_value_in, cdb_addr_in;
    logic [PTR_W-1:0]        src1_ix_in, src2_ix_in;
    logic [XLEN-1:0]         src1_value_out, src2_value_out;
    logic                    src1_ready_out, src2_ready_out;
    logic                    commit_valid_out, store_valid_out, store_ack_in;
    logic [PTR_W-1:0]        commit_ix_out;
    logic [3:0]              commit_itype_out;
    logic [XLEN-1:0]         commit_value_out, commit_dest_out;
    logic                    flush_valid_in;
    logic [PTR_W-1:0]        flush_ix_in;
    logic [NUM_LD*PTR_W-1:0] ld_ix_in;
    logic [NUM_LD*XLEN-1:0]  ld_addr_in;
    logic [NUM_LD-1:0]       can_load_out;
    logic [PTR_W:0]          count_out;

    always #5 clk_in = ~clk_in;

    rob_param #(.SIZE(SIZE), .XLEN(XLEN), .NUM_LD(NUM_LD)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .alloc_valid_in(alloc_valid_in), .alloc_itype_in(alloc_itype_in),
        .alloc_value_in(alloc_value_in), .alloc_dest_in(alloc_dest_in),
        .alloc_ready_out(alloc_ready_out), .alloc_ix_out(alloc_ix_out),
        .cdb_valid_in(cdb_valid_in), .cdb_ix_in(cdb_ix_in),
        .cdb_value_in(cdb_value_in), .cdb_addr_in(cdb_addr_in),
        .src1_ix_in(src1_ix_in), .src2_ix_in(src2_ix_in),
        .src1_value_out(src1_value_out), .src2_value_out(src2_value_out),
        .src1_ready_out(src1_ready_out), .src2_ready_out(src2_ready_out),
        .commit_valid_out(commit_valid_out), .store_valid_out(store_valid_out),
        .store_ack_in(store_ack_in), .commit_ix_out(commit_ix_out),
        .commit_itype_out(commit_itype_out), .commit_value_out(commit_value_out),
        .commit_dest_out(commit_dest_out),
        .flush_valid_in(flush_valid_in), .flush_ix_in(flush_ix_in),
        .ld_ix_in(ld_ix_in), .ld_addr_in(ld_addr_in),
        .can_load_out(can_load_out), .count_out(count_out)
    );

    // Reference model: entries in age order, oldest first, plus the head slot number.
    typedef struct {
        logic [3:0]      itype;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] dest;
        bit              ready;
    } ent_t;

    ent_t rob[$];
    int   hs;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int age(input int slot);
        return (slot - hs + SIZE) % SIZE;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit              hr, ok;
        int              a, al;
        logic [PTR_W-1:0] ix;
        logic [XLEN-1:0] la;
        check("count", count_out, rob.size());
        check("alloc_rdy", alloc_ready_out, (rob.size() < SIZE) && !flush_valid_in);
        check("alloc_ix", alloc_ix_out, (hs + rob.size()) % SIZE);
        check("commit_ix", commit_ix_out, hs);
        hr = 1'b0;
        if (rob.size() > 0) hr = rob[0].ready;
        if (hr) begin
            check("commit_vld", commit_valid_out, rob[0].itype != ST);
            check("store_vld", store_valid_out, rob[0].itype == ST);
            check("commit_itype", commit_itype_out, rob[0].itype);
            check("commit_value", commit_value_out, rob[0].value);
            check("commit_dest", commit_dest_out, rob[0].dest);
        end else begin
            check("commit_vld", commit_valid_out, 0);
            check("store_vld", store_valid_out, 0);
        end
        for (int s = 0; s < 2; s++) begin
            ix = (s == 0) ? src1_ix_in : src2_ix_in;
            if (cdb_valid_in && cdb_ix_in == ix) begin
                check("src_byp_rdy", (s == 0) ? src1_ready_out : src2_ready_out, 1);
                check("src_byp_val", (s == 0) ? src1_value_out : src2_value_out, cdb_value_in);
            end else begin
                a = age(ix);
                if (a < rob.size()) begin
                    check("src_rdy", (s == 0) ? src1_ready_out : src2_ready_out, rob[a].ready);
                    if (rob[a].ready)
                        check("src_val", (s == 0) ? src1_value_out : src2_value_out, rob[a].value);
                end
            end
        end
        for (int i = 0; i < NUM_LD; i++) begin
            al = age(ld_ix_in[i*PTR_W +: PTR_W]);
            la = ld_addr_in[i*XLEN +: XLEN];
            ok = 1'b1;
            for (int k = 0; k < al && k < rob.size(); k++)
                if (rob[k].itype == ST && (!rob[k].ready || rob[k].dest == la)) ok = 1'b0;
            check("can_load", can_load_out[i], ok);
        end
    endtask

    task automatic update_model();
        bit   retire;
        int   d, a;
        ent_t e;
        if (rst_in) begin
            rob.delete();
            hs = 0;
            return;
        end
        retire = 1'b0;
        if (rob.size() > 0 && rob[0].ready) retire = (rob[0].itype != ST) || store_ack_in;
        d = flush_valid_in ? age(flush_ix_in) : SIZE;
        a = age(cdb_ix_in);
        if (cdb_valid_in && a < rob.size() && a <= d) begin
            e = rob[a];
            e.ready = 1'b1;
            e.value = cdb_value_in;
            if (e.itype == ST) e.dest = e.dest + cdb_addr_in;
            rob[a] = e;
        end
        if (flush_valid_in)
            while (rob.size() > d + 1) void'(rob.pop_back());
        if (alloc_valid_in && rob.size() < SIZE && !flush_valid_in) begin
            e.itype = alloc_itype_in;
            e.value = alloc_value_in;
            e.dest  = alloc_dest_in;
            e.ready = 1'b0;
            rob.push_back(e);
        end
        if (retire) begin
            void'(rob.pop_front());
            hs = (hs + 1) % SIZE;
        end
    endtask

    task automatic step();
        #1;
        compare_all();
        @(posedge clk_in);
        update_model();
        @(negedge clk_in);
    endtask

    task automatic idle();
        alloc_valid_in = 1'b0; alloc_itype_in = ALU; alloc_value_in = '0; alloc_dest_in = '0;
        cdb_valid_in = 1'b0; cdb_ix_in = '0; cdb_value_in = '0; cdb_addr_in = '0;
        src1_ix_in = '0; src2_ix_in = '0; store_ack_in = 1'b0;
        flush_valid_in = 1'b0; flush_ix_in = '0;
    endtask

    task automatic do_alloc(input logic [3:0] t, input logic [XLEN-1:0] v, input logic [XLEN-1:0] d);
        idle();
        alloc_valid_in = 1'b1; alloc_itype_in = t; alloc_value_in = v; alloc_dest_in = d;
        step();
    endtask

    task automatic do_cdb(input int ix, input logic [XLEN-1:0] v, input logic [XLEN-1:0] a);
        idle();
        cdb_valid_in = 1'b1; cdb_ix_in = PTR_W'(ix); cdb_value_in = v; cdb_addr_in = a;
        step();
    endtask

    task automatic drain();
        for (int k = 0; k < 3 * SIZE && rob.size() > 0; k++) begin
            idle();
            step();
        end
        check("drained", count_out, 0);
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        ld_ix_in = '0;
        ld_addr_in = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        rob.delete();
        hs = 0;
        #1;
        check("rst_alloc_rdy", alloc_ready_out, 1);
        check("rst_count", count_out, 0);
        check("rst_can_load", can_load_out, 3'b111);
        step();

        // Fill to capacity; the ninth request must be refused.
        for (int k = 0; k < 9; k++) begin
            idle();
            alloc_valid_in = 1'b1; alloc_itype_in = ALU;
            alloc_value_in = XLEN'(k); alloc_dest_in = XLEN'(k);
            if (k == 8) begin
                #1;
                check("full_no_rdy", alloc_ready_out, 0);
                check("full_count", count_out, 8);
            end
            step();
        end

        // CDB bypass to decode, then in-order commit.
        idle();
        cdb_valid_in = 1'b1; cdb_ix_in = 3'd2; cdb_value_in = 32'h55; src1_ix_in = 3'd2;
        #1;
        check("byp_val", src1_value_out, 32'h55);
        check("byp_rdy", src1_ready_out, 1);
        step();
        for (int s = 0; s < SIZE; s++)
            if (s != 2) do_cdb(s, 32'h10 + XLEN'(s), 32'h0);
        drain();

        // Store with address resolution and a delayed ack.
        idle();
        #1;
        check("st_slot", alloc_ix_out, 0);
        do_alloc(ST, 32'h0, 32'h100);
        do_cdb(0, 32'hAB, 32'h20);
        for (int k = 0; k < 3; k++) begin
            idle();
            #1;
            check("st_hold_vld", store_valid_out, 1);
            check("st_hold_dest", commit_dest_out, 32'h120);
            step();
        end
        idle();
        store_ack_in = 1'b1;
        step();
        idle();
        #1;
        check("st_acked", count_out, 0);
        step();

        // Wrap-around flush with a dropped alloc and an ignored CDB to a squashed slot.
        for (int k = 0; k < 5; k++) do_alloc(ALU, 32'h0, 32'h0);
        for (int s = 1; s <= 5; s++) do_cdb(s, 32'h20 + XLEN'(s), 32'h0);
        drain();
        for (int k = 0; k < 6; k++) do_alloc(ALU, 32'h0, 32'h0);
        idle();
        flush_valid_in = 1'b1; flush_ix_in = 3'd7;
        alloc_valid_in = 1'b1;
        cdb_valid_in = 1'b1; cdb_ix_in = 3'd0; cdb_value_in = 32'h99;
        #1;
        check("flush_alloc_blk", alloc_ready_out, 0);
        step();
        idle();
        #1;
        check("flush_count", count_out, 2);
        check("flush_tail", alloc_ix_out, 0);
        step();
        do_cdb(6, 32'h66, 32'h0);
        do_cdb(7, 32'h77, 32'h0);
        drain();

        // Load ordering against an older store, head at slot 4.
        for (int k = 0; k < 4; k++) do_alloc(ALU, 32'h0, 32'h0);
        for (int s = 0; s < 4; s++) do_cdb(s, 32'h30, 32'h0);
        drain();
        do_alloc(ALU, 32'h0, 32'h0);
        do_alloc(ST, 32'h5, 32'h30);
        for (int k = 0; k < 3; k++) do_alloc(ALU, 32'h0, 32'h0);
        do_alloc(LD, 32'h0, 32'h0);
        ld_ix_in = {3'd4, 3'd5, 3'd1};
        ld_addr_in = {32'h0, 32'h0, 32'h44};
        idle();
        #1;
        check("ld_unres_store", can_load_out[0], 0);
        step();
        do_cdb(5, 32'h77, 32'h10);
        idle();
        #1;
        check("ld_no_alias", can_load_out[0], 1);
        step();
        ld_addr_in[31:0] = 32'h40;
        #1;
        check("ld_alias", can_load_out[0], 0);
        step();

        // Reset while a store waits for the memory unit.
        do_cdb(4, 32'h44, 32'h0);
        idle();
        step();
        idle();
        #1;
        check("pre_rst_st", store_valid_out, 1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        #1;
        check("rst2_alloc_ix", alloc_ix_out, 0);
        check("rst2_count", count_out, 0);
        check("rst2_store", store_valid_out, 0);
        check("rst2_commit", commit_valid_out, 0);
        check("rst2_can_load", can_load_out, 3'b111);
        step();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            idle();
            rst_in = ($urandom % 500) == 0;
            alloc_valid_in = ($urandom % 3) != 0;
            alloc_itype_in = 4'($urandom % 4);
            alloc_value_in = $urandom;
            alloc_dest_in = 32'h100 + 32'($urandom % 4) * 32'h40;
            cdb_valid_in = 1'($urandom % 2);
            cdb_ix_in = PTR_W'($urandom);
            cdb_value_in = $urandom;
            cdb_addr_in = ($urandom % 2) != 0 ? 32'h40 : 32'h0;
            src1_ix_in = PTR_W'($urandom);
            src2_ix_in = PTR_W'($urandom);
            store_ack_in = 1'($urandom % 2);
            if (rob.size() > 0 && ($urandom % 16) == 0) begin
                flush_valid_in = 1'b1;
                flush_ix_in = PTR_W'((hs + int'($urandom % rob.size())) % SIZE);
            end
            for (int i = 0; i < NUM_LD; i++) begin
                ld_ix_in[i*PTR_W +: PTR_W] = PTR_W'($urandom);
                ld_addr_in[i*XLEN +: XLEN] = 32'h100 + 32'($urandom % 6) * 32'h40;
            end
            step();
        end
        rst_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer for the out-of-order core, sitting between issue/decode, the CDB, the register-file commit path and the store unit.
- Generalises the fixed 8-entry ROB: configurable depth, data width and load-check channel count, with true wrap-around age ordering.
- Adds branch-mispredict flush, same-cycle CDB bypass to decode operand reads, and an occupancy output.

Parameters:
- SIZE, 8, entry count; power of two, at least 2.
- XLEN, 32, width of value/dest fields.
- NUM_LD, 3, number of load-buffer entries checked for store conflicts.
- PTR_W, $clog2(SIZE), slot index width (localparam).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset.
- alloc_valid_in  input  1  issue requests an entry.
- alloc_itype_in  input  4  instruction type; STORE code from types.svh.
- alloc_value_in  input  XLEN  initial value (store data base / immediate).
- alloc_dest_in  input  XLEN  register index, or store base offset.
- alloc_ready_out  output  1  entry available.
- alloc_ix_out  output  PTR_W  slot the next allocation receives.
- cdb_valid_in  input  1  CDB broadcast valid.
- cdb_ix_in  input  PTR_W  target slot.
- cdb_value_in  input  XLEN  result value.
- cdb_addr_in  input  XLEN  address component, added to dest for STORE.
- src1_ix_in, src2_ix_in  input  PTR_W  decode operand lookup slots.
- src1_value_out, src2_value_out  output  XLEN  looked-up values.
- src1_ready_out, src2_ready_out  output  1  looked-up value valid.
- commit_valid_out  output  1  head is a ready non-store; it retires this edge.
- store_valid_out  output  1  head is a ready store awaiting the memory unit.
- store_ack_in  input  1  memory unit accepted the head store.
- commit_ix_out  output  PTR_W  head slot.
- commit_itype_out  output  4  head type.
- commit_value_out  output  XLEN  head value.
- commit_dest_out  output  XLEN  head dest/address.
- flush_valid_in  input  1  mispredict; squash entries younger than flush_ix_in.
- flush_ix_in  input  PTR_W  slot of the mispredicted branch (kept).
- ld_ix_in  input  NUM_LD*PTR_W  packed ROB slots of loads.
- ld_addr_in  input  NUM_LD*XLEN  packed load addresses.
- can_load_out  output  NUM_LD  load i has no older unresolved or aliasing store.
- count_out  output  PTR_W+1  occupied entries.

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset: head=tail=0; all valid/ready bits cleared. Resulting outputs: alloc_ready_out=1, alloc_ix_out=0, count_out=0, commit_valid_out=0, store_valid_out=0, can_load_out all 1.
- Reset mid-operation discards every entry, including an outstanding store.
- Pointers are PTR_W+1 bits. count = tail-head (mod 2^(PTR_W+1)). Full when count==SIZE; empty when count==0. Slot = ptr[PTR_W-1:0]; pointers wrap naturally.
- alloc_ready_out = !full && !flush_valid_in. It is combinational and ignores a same-cycle commit, so full stays full for that cycle.
- Allocation occurs when alloc_valid_in && alloc_ready_out: the slot is written, valid=1, ready=0, and tail increments.
- CDB write when cdb_valid_in and the target slot is valid: value<=cdb_value_in, ready<=1; if the slot is STORE, dest<=dest+cdb_addr_in (XLEN wrap).
  - CDB to an invalid slot is ignored.
  - CDB to a slot squashed in the same cycle is ignored.
- Commit output fields are combinational from the head slot.
  - commit_valid_out = !empty && ready && type!=STORE; head advances on that edge and the slot is invalidated.
  - store_valid_out = !empty && ready && type==STORE; it holds until store_ack_in, and head advances on the ack edge.
  - store_ack_in without store_valid_out is ignored.
- Flush: d=(flush_ix_in-head slot) mod SIZE; tail<=head_old+d+1; slots beyond are invalidated.
  - A same-cycle commit of head still occurs, since head is never younger than the branch.
  - flush_ix_in must reference a valid entry; otherwise behaviour is undefined.
- Operand lookup: src value/ready come from the slot. If cdb_valid_in && cdb_ix_in==src_ix, the CDB value is forwarded with ready=1 (0-cycle bypass).
- Load check, per i: can_load_out[i]=0 if any valid slot j with age(j)<age(ld_ix[i]) is a STORE and is either not ready or has dest==ld_addr[i].
  - age(x)=(x-head slot) mod SIZE.
  - Combinational; correct across wrap-around.
- count_out reflects registered pointers only.

Test Plan:
- Reset, then allocate 8 entries back-to-back -> alloc_ix_out 0..7, count_out=8, alloc_ready_out=0 on the 9th request; no write occurs.
- CDB to slot 2 (value 0x55) while src1_ix_in=2 -> src1_value_out=0x55, src1_ready_out=1 same cycle; commits follow in order once slots 0,1 are ready.
- Store at slot 0 with dest=0x100, CDB cdb_addr_in=0x20 -> store_valid_out=1, commit_dest_out=0x120. store_ack_in delayed 3 cycles -> head holds for 3 cycles, then advances.
- Wrap: head=6 with 6 entries (slots 6,7,0,1,2,3), flush_ix_in=7 -> tail=head+2, count_out=2. A simultaneous alloc is dropped, and a CDB to slot 0 is ignored.
- Store at slot 5 (unready) older than load at slot 1 with head=4 -> can_load_out[0]=0. After CDB resolves the store to addr 0x40 with load addr 0x44 -> 1; with load addr 0x40 -> 0.
- Reset asserted while store_valid_out=1 -> next cycle all outputs at reset values.
